instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Produces the `instruction_code` stream consumed by `instruction_decoder`. It does this by fetching 32-bit words from instruction memory at a program counter (PC), buffering them in a small FIFO, and presenting them to the decoder with a valid/ready handshake. It sits between the instruction-memory port and the decoder. Control-flow changes (jal, branches, mret, traps) arrive as a single-cycle redirect that flushes all buffered and in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0200_0000, PC loaded on reset.
- `FIFO_DEPTH`, default 2, instruction buffer entries (power of two, ≥2).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  fetch enable; gates only the launch of new requests.
- `imem_req`  out  1  memory read request.
- `imem_addr`  out  32  word address = PC.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  read data.
- `redirect_valid`  in  1  one-cycle PC redirect.
- `redirect_pc`  in  32  redirect target.
- `inst_valid`  out  1  FIFO head valid.
- `inst_ready`  in  1  decoder accepts head.
- `instruction_code`  out  32  FIFO head word; 32'd0 when empty.
- `inst_pc`  out  32  PC of FIFO head; 32'd0 when empty.
- `fetch_misaligned`  out  1  PC[1:0]≠0; fetch halted.

## Operation
- FSM states:
  - IDLE: `imem_req`=0.
  - REQ: `imem_req`=1, `imem_addr`=PC.
  - WAIT: one request outstanding.
  - FLUSH: discard one in-flight response.
  - ERR: misaligned PC.
- At most one outstanding request.
- IDLE→REQ when `en` && count<FIFO_DEPTH && PC[1:0]==0. IDLE→ERR if PC[1:0]≠0.
- REQ: `imem_req` and `imem_addr` stay stable until `imem_gnt`, even if `en` drops. On gnt: PC←PC+4 (wraps mod 2^32), go to WAIT.
- WAIT: on `imem_rvalid`, push {rdata, fetched PC} into the FIFO. Next state is REQ if `en` && count_next<FIFO_DEPTH, else IDLE.
- Pop occurs when `inst_valid && inst_ready`. Simultaneous push and pop leaves count unchanged. Because a request is only issued when space exists, overflow is impossible.
- Redirect has the highest priority, in any state:
  - FIFO cleared.
  - PC←redirect_pc.
  - Next state is FLUSH if a response is still owed (in WAIT, or in REQ with gnt this cycle). Otherwise the next state is REQ, or ERR if redirect_pc[1:0]≠0.
  - A push in the same cycle as a redirect is discarded.
- FLUSH: `imem_req`=0. The first `imem_rvalid` is dropped, then proceed as from IDLE. A redirect while in FLUSH updates PC and stays in FLUSH.
- ERR: `fetch_misaligned`=1, `imem_req`=0. Left only on a redirect with aligned target.

## Timing
- Reset values:
  - PC=RESET_PC, state IDLE, FIFO empty.
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `inst_valid`=0, `instruction_code`=0, `inst_pc`=0, `fetch_misaligned`=0.
- Reset mid-operation abandons any outstanding request. The memory model must not return data after `rst`.
- First `imem_req` is no earlier than the first cycle after reset deassertion with `en`=1.
- `imem_rvalid` in cycle N gives `inst_valid`=1 in cycle N+1. Outputs are registered; there is no combinational rdata→instruction_code path.
- Redirect in cycle N gives `inst_valid`=0 in cycle N+1. The new `imem_req` is issued in N+1 if no drain is needed.
- Peak throughput with single-cycle memory (gnt in REQ, rvalid the next cycle): one instruction per 2 cycles.
- Head is held stable while `inst_valid && !inst_ready`.

## Structure
- Shared `cpu_pkg` holds:
  - `XLEN`/`ILEN`=32.
  - Default `RESET_PC`.
  - Fetch FSM state enum.
  - Instruction-alignment constant (PC increment 4).
- Sub-module `fetch_fifo`: synchronous FIFO of {pc, instr}, width 64, depth FIFO_DEPTH, with push/pop/clear/count.
- The FSM and PC stay in the top module.

## Test plan
- Reset, `en`=1, memory returns 32'h00000797, 32'h02c78793 → `inst_pc` 32'h0200_0000 then 32'h0200_0004; decoder flags auipc then addi.
- `inst_ready`=0 for 20 cycles → exactly FIFO_DEPTH words buffered, `imem_req` stays 0, head unchanged; releasing ready resumes fetch in order.
- Redirect to 32'h0200_09c4 while in WAIT → late rvalid discarded, next `inst_pc`=32'h0200_09c4, no stale word (e.g. 32'h1a5000ef) reaches the decoder.
- Redirect to 32'h0200_0002 → `fetch_misaligned`=1, `imem_req`=0; a later redirect to 32'h0200_0010 clears it and fetching resumes.
- `imem_gnt` held low 5 cycles with `en` dropped mid-REQ → `imem_req` and `imem_addr` stable until gnt, then IDLE.
- `rst` asserted during WAIT → next cycle all outputs at reset values, PC=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC, fetch FSM encodings and
// the instruction-alignment helpers used by the fetch unit.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0200_0000;
    localparam logic [XLEN-1:0] INST_ALIGN_INC   = 32'd4;

    // Fetch FSM encodings, kept as plain constants for legacy tools.
    typedef logic [2:0] fetch_state_t;
    localparam fetch_state_t FS_IDLE  = 3'd0;
    localparam fetch_state_t FS_REQ   = 3'd1;
    localparam fetch_state_t FS_WAIT  = 3'd2;
    localparam fetch_state_t FS_FLUSH = 3'd3;
    localparam fetch_state_t FS_ERR   = 3'd4;

    // A fetch PC must be word aligned; anything else halts the fetcher.
    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} pairs between the memory port and
// the decoder. Clear has priority over push and pop in the same cycle.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset; entries need no reset because
    // the head is qualified by count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks the PC through instruction memory with at most
// one outstanding request, buffers returned words and hands them to the
// decoder. A redirect flushes everything and retargets the PC.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] instruction_code,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_misaligned
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

    logic                   push_s;
    logic                   pop_s;
    logic                   resp_owed_s;
    logic [CW-1:0]          fifo_count_s;
    logic [CW-1:0]          count_next_s;
    logic [XLEN+ILEN-1:0]   fifo_head_s;

    // A response from a cancelled fetch arriving with a redirect is dropped.
    assign push_s = (state_q == FS_WAIT) && imem_rvalid && !redirect_valid;
    assign pop_s  = inst_valid && inst_ready;

    // A response is still owed if one was granted and has not come back yet,
    // including one arriving in this very cycle's grant.
    assign resp_owed_s = ((state_q == FS_REQ) && imem_gnt) ||
                         (((state_q == FS_WAIT) || (state_q == FS_FLUSH)) && !imem_rvalid);

    // Occupancy after this cycle's push/pop, used to decide whether to refetch.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = fifo_count_s + CW'(1);
            2'b01:   count_next_s = fifo_count_s - CW'(1);
            default: count_next_s = fifo_count_s;
        endcase
    end

    // Fetch FSM and PC update; redirect overrides every state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
            if (resp_owed_s) begin
                state_d = FS_FLUSH;
            end else if (pc_misaligned(redirect_pc)) begin
                state_d = FS_ERR;
            end else begin
                state_d = FS_REQ;
            end
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if (pc_misaligned(pc_q)) begin
                        state_d = FS_ERR;
                    end else if (en && (fifo_count_s < DEPTH_C)) begin
                        state_d = FS_REQ;
                    end else begin
                        state_d = FS_IDLE;
                    end
                end
                FS_REQ: begin
                    if (imem_gnt) begin
                        fetch_pc_d = pc_q;
                        pc_d       = pc_q + INST_ALIGN_INC;
                        state_d    = FS_WAIT;
                    end else begin
                        state_d = FS_REQ;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        if (en && (count_next_s < DEPTH_C)) begin
                            state_d = FS_REQ;
                        end else begin
                            state_d = FS_IDLE;
                        end
                    end else begin
                        state_d = FS_WAIT;
                    end
                end
                FS_FLUSH: begin
                    if (imem_rvalid) begin
                        state_d = FS_IDLE;
                    end else begin
                        state_d = FS_FLUSH;
                    end
                end
                FS_ERR:  state_d = FS_ERR;
                default: state_d = FS_IDLE;
            endcase
        end
    end

    // FSM, PC and in-flight PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FS_IDLE;
            pc_q       <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .clear     (redirect_valid),
        .push_data ({fetch_pc_q, imem_rdata}),
        .head_data (fifo_head_s),
        .count     (fifo_count_s)
    );

    // All outputs decode registered state only.
    assign imem_req         = (state_q == FS_REQ);
    assign imem_addr        = pc_q;
    assign fetch_misaligned = (state_q == FS_ERR);
    assign inst_valid       = (fifo_count_s != {CW{1'b0}});
    assign instruction_code = inst_valid ? fifo_head_s[ILEN-1:0]         : 32'd0;
    assign inst_pc          = inst_valid ? fifo_head_s[XLEN+ILEN-1:ILEN] : 32'd0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a one-outstanding memory
// responder whose grant and response can be held off.
module tb_instruction_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RPC   = 32'h0200_0000;
    localparam logic [31:0] STALE = 32'h1a50_00ef;

    logic        clk = 1'b0;
    logic        rst, en;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] instruction_code, inst_pc;
    logic        fetch_misaligned;

    logic        gnt_allow, rvalid_allow;
    logic        pend_q;
    logic [31:0] paddr_q;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          c0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .instruction_code (instruction_code),
        .inst_pc          (inst_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    // Memory contents: a few fixed words, otherwise an address-derived pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0200_0000: mem_word = 32'h0000_0797;
            32'h0200_0004: mem_word = 32'h02c7_8793;
            32'h0200_0200: mem_word = STALE;
            default:       mem_word = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign imem_gnt    = gnt_allow & imem_req;
    assign imem_rvalid = pend_q & rvalid_allow;
    assign imem_rdata  = mem_word(paddr_q);

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: remembers the granted address, answers when allowed.
    always @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else if (imem_req && imem_gnt) begin
            pend_q  <= 1'b1;
            paddr_q <= imem_addr;
        end else if (imem_rvalid) begin
            pend_q <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!inst_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        gnt_allow = 1'b1; rvalid_allow = 1'b1;
        step(3);
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr, RPC);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_code",  instruction_code, 32'd0);
        check("rst_pc",    inst_pc, 32'd0);
        check("rst_mis",   {31'd0, fetch_misaligned}, 32'd0);

        // Basic fetch: auipc then addi, two cycles apart.
        rst = 1'b0; en = 1'b1; inst_ready = 1'b1;
        wait_valid(20);
        c0 = cyc;
        check("f1_valid", {31'd0, inst_valid}, 32'd1);
        check("f1_pc",    inst_pc, 32'h0200_0000);
        check("f1_code",  instruction_code, 32'h0000_0797);
        check("f1_auipc", {25'd0, instruction_code[6:0]}, 32'h17);
        wait_valid(20);
        check("f2_pc",    inst_pc, 32'h0200_0004);
        check("f2_code",  instruction_code, 32'h02c7_8793);
        check("f2_addi",  {25'd0, instruction_code[6:0]}, 32'h13);
        check("f2_gap",   cyc - c0, 32'd2);

        // Backpressure: redirect with decoder stalled fills exactly two entries.
        inst_ready = 1'b0;
        do_redirect(32'h0200_0100);
        check("bp_flushed", {31'd0, inst_valid}, 32'd0);
        step(5);
        check("bp_head5", inst_pc, 32'h0200_0100);
        step(15);
        check("bp_valid", {31'd0, inst_valid}, 32'd1);
        check("bp_head",  inst_pc, 32'h0200_0100);
        check("bp_code",  instruction_code, mem_word(32'h0200_0100));
        check("bp_req",   {31'd0, imem_req}, 32'd0);
        check("bp_addr",  imem_addr, 32'h0200_0108);
        inst_ready = 1'b1;
        wait_valid(20);
        check("bp_pc1", inst_pc, 32'h0200_0104);
        wait_valid(20);
        check("bp_pc2", inst_pc, 32'h0200_0108);
        wait_valid(20);
        check("bp_pc3", inst_pc, 32'h0200_010c);
        check("bp_code3", instruction_code, mem_word(32'h0200_010c));

        // Redirect while waiting: late response must be discarded.
        en = 1'b0;
        step(10);
        rvalid_allow = 1'b0;
        do_redirect(32'h0200_0200);
        step(3);
        check("rw_wait_req", {31'd0, imem_req}, 32'd0);
        check("rw_pending",  {31'd0, pend_q}, 32'd1);
        do_redirect(32'h0200_09c4);
        rvalid_allow = 1'b1; en = 1'b1;
        check("rw_flush_valid", {31'd0, inst_valid}, 32'd0);
        check("rw_flush_req",   {31'd0, imem_req}, 32'd0);
        wait_valid(20);
        check("rw_pc",    inst_pc, 32'h0200_09c4);
        check("rw_code",  instruction_code, mem_word(32'h0200_09c4));
        check("rw_stale", {31'd0, instruction_code == STALE}, 32'd0);

        // Misaligned redirect halts fetch until an aligned redirect.
        do_redirect(32'h0200_0002);
        n = 0;
        while (!fetch_misaligned && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("mis_flag",  {31'd0, fetch_misaligned}, 32'd1);
        check("mis_req",   {31'd0, imem_req}, 32'd0);
        check("mis_valid", {31'd0, inst_valid}, 32'd0);
        step(3);
        check("mis_hold",  {31'd0, fetch_misaligned}, 32'd1);
        check("mis_req2",  {31'd0, imem_req}, 32'd0);
        do_redirect(32'h0200_0010);
        check("mis_clear", {31'd0, fetch_misaligned}, 32'd0);
        check("mis_rreq",  {31'd0, imem_req}, 32'd1);
        check("mis_raddr", imem_addr, 32'h0200_0010);
        wait_valid(20);
        check("mis_pc",    inst_pc, 32'h0200_0010);
        check("mis_code",  instruction_code, mem_word(32'h0200_0010));

        // Grant withheld: request held stable after en drops.
        en = 1'b0;
        step(10);
        gnt_allow = 1'b0; en = 1'b1;
        do_redirect(32'h0200_0300);
        check("gnt_req0",  {31'd0, imem_req}, 32'd1);
        check("gnt_addr0", imem_addr, 32'h0200_0300);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("gnt_hold", {imem_req, imem_addr[30:0]}, {1'b1, 31'h0200_0300});
        end
        gnt_allow = 1'b1;
        step(1);
        check("gnt_wait_req", {31'd0, imem_req}, 32'd0);
        wait_valid(10);
        check("gnt_pc", inst_pc, 32'h0200_0300);
        step(2);
        check("gnt_idle_req",  {31'd0, imem_req}, 32'd0);
        check("gnt_idle_addr", imem_addr, 32'h0200_0304);

        // Reset during WAIT returns everything to reset values.
        rvalid_allow = 1'b0; en = 1'b1;
        do_redirect(32'h0200_0400);
        step(1);
        check("rw2_wait_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        step(1);
        check("mr_req",   {31'd0, imem_req}, 32'd0);
        check("mr_addr",  imem_addr, RPC);
        check("mr_valid", {31'd0, inst_valid}, 32'd0);
        check("mr_code",  instruction_code, 32'd0);
        check("mr_pc",    inst_pc, 32'd0);
        check("mr_mis",   {31'd0, fetch_misaligned}, 32'd0);
        rst = 1'b0; rvalid_allow = 1'b1;
        wait_valid(20);
        check("mr_fpc",   inst_pc, RPC);
        check("mr_fcode", instruction_code, 32'h0000_0797);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
